// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the 4-lane interleaved data memory: validates requests,
// drives memory pins with lane-replicated store data and returns load results or address errors.
module mem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_width,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_exc,
  output logic              mem_we,
  output logic [1:0]        mem_dwidth,
  output logic              mem_sign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_bit_error,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] EXC_OK = 2'b00;
  localparam logic [1:0] EXC_LD = 2'b01;
  localparam logic [1:0] EXC_ST = 2'b10;

  logic [1:0]        r_state;
  logic              r_we;
  logic [1:0]        r_width;
  logic              r_sign;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [1:0]        r_exc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_out_of_range;
  logic              w_req_err;
  logic [CNT_W-1:0]  w_cnt_next;

  // Any address bit at or above ADDR_W makes the request out of range.
  assign w_out_of_range = (req_addr >> ADDR_W) != '0;
  assign w_req_err = (req_width == 2'b10)
                   | ((req_width == 2'b01) & req_addr[0])
                   | ((req_width == 2'b11) & (req_addr[1:0] != 2'b00))
                   | w_out_of_range;
  assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_width <= '0;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_exc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_width <= req_width;
            r_sign  <= req_sign;
            r_addr  <= req_addr[ADDR_W-1:0];
            r_wdata <= req_wdata;
            r_rdata <= '0;
            if (w_req_err) begin
              r_exc   <= req_we ? EXC_ST : EXC_LD;
              r_cnt   <= w_cnt_next;
              r_state <= S_RESP;
            end else begin
              r_exc   <= EXC_OK;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_bit_error) begin
            r_exc   <= r_we ? EXC_ST : EXC_LD;
            r_cnt   <= w_cnt_next;
            r_state <= S_RESP;
          end else if (r_we) begin
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_rdata <= mem_rdata;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (r_width)
      2'b00:   mem_wdata = {4{r_wdata[7:0]}};
      2'b01:   mem_wdata = {2{r_wdata[15:0]}};
      default: mem_wdata = r_wdata;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_exc   = r_exc;
  assign mem_we     = (r_state == S_ISSUE) & r_we;
  assign mem_dwidth = r_width;
  assign mem_sign   = r_sign;
  assign mem_addr   = r_addr;
  assign err_count  = r_cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: little-endian byte-array memory stub, transaction-level
// reference model, per-cycle output compare, directed and random request streams.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        mem_we;
  logic [1:0]  mem_dwidth;
  logic        mem_sign;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_bit_error;
  logic [7:0]  err_count;
  logic        inj = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_exc(resp_exc), .mem_we(mem_we),
    .mem_dwidth(mem_dwidth), .mem_sign(mem_sign), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_bit_error(mem_bit_error),
    .err_count(err_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] w, input logic s);
    case (w)
      2'b00:   return s ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      2'b01:   return s ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] rep(input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Memory device stub: registered read, write suppressed on bit_error.
  bit [7:0] dmem [0:65535];
  bit [7:0] rmem [0:65535];
  logic [15:0] da;
  assign da = mem_addr;
  assign mem_bit_error = inj | (mem_dwidth == 2'b10) | ((mem_dwidth == 2'b01) & da[0])
                       | ((mem_dwidth == 2'b11) & (da[1:0] != 2'b00));

  always @(posedge clk) begin
    mem_rdata <= ext({dmem[da + 16'd3], dmem[da + 16'd2], dmem[da + 16'd1], dmem[da]},
                     mem_dwidth, mem_sign);
    if (mem_we && !mem_bit_error) begin
      for (int unsigned k = 0; k < 4; k++) begin
        logic [15:0] ba;
        logic [1:0]  lane;
        ba = da + 16'(k);
        lane = ba[1:0];
        if (mem_dwidth == 2'b11 || (mem_dwidth == 2'b01 && k < 2) || k == 0)
          dmem[ba] <= mem_wdata[8*lane +: 8];
      end
    end
  end

  // Transaction-level reference model.
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_acc = 0;
  int          m_lat = 0;
  logic [1:0]  m_exc = '0;
  logic [31:0] m_rdata = '0;
  bit          m_we_iss = 0;
  bit          m_pend = 0;
  logic [7:0]  m_err = '0;
  logic [15:0] m_addr = '0;
  logic [1:0]  m_w = '0;
  logic        m_s = 1'b0;
  logic [31:0] m_wd = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_pend = 0; m_err = '0;
      m_addr = '0; m_w = '0; m_s = 1'b0; m_wd = '0;
      m_exc = '0; m_rdata = '0;
    end else if (m_busy && (cyc - m_acc) >= m_lat && resp_ready) begin
      m_busy = 0;
    end else if (m_busy && m_pend && (cyc - m_acc) == 1) begin
      m_pend = 0;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else if (!m_busy && req_valid) begin
      logic pre;
      logic [15:0] a;
      m_busy = 1; m_acc = cyc; m_pend = 0; m_we_iss = 0; m_rdata = '0;
      m_addr = req_addr[15:0]; m_w = req_width; m_s = req_sign; m_wd = req_wdata;
      a = req_addr[15:0];
      pre = (req_width == 2'b10) || (req_width == 2'b01 && req_addr[0])
         || (req_width == 2'b11 && req_addr[1:0] != 2'b00) || (req_addr[31:16] != 16'h0);
      if (pre) begin
        m_lat = 1; m_exc = req_we ? 2'b10 : 2'b01;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end else if (inj) begin
        m_lat = 2; m_exc = req_we ? 2'b10 : 2'b01; m_pend = 1; m_we_iss = req_we;
      end else if (req_we) begin
        m_lat = 2; m_exc = 2'b00; m_we_iss = 1;
        rmem[a] = req_wdata[7:0];
        if (req_width != 2'b00) rmem[a + 16'd1] = req_wdata[15:8];
        if (req_width == 2'b11) begin
          rmem[a + 16'd2] = req_wdata[23:16];
          rmem[a + 16'd3] = req_wdata[31:24];
        end
      end else begin
        m_lat = 3; m_exc = 2'b00;
        m_rdata = ext({rmem[a + 16'd3], rmem[a + 16'd2], rmem[a + 16'd1], rmem[a]},
                      req_width, req_sign);
      end
    end
    cyc++;
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int  n;
      bit  ev, ew;
      n  = cyc - m_acc;
      ev = m_busy && n >= m_lat;
      ew = m_busy && m_we_iss && n == 1;
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("mem_we", 32'(mem_we), 32'(ew));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_dwidth", 32'(mem_dwidth), 32'(m_w));
      chk("mem_sign", 32'(mem_sign), 32'(m_s));
      if (ew) chk("mem_wdata", mem_wdata, rep(m_wd, m_w));
      if (ev) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_exc", 32'(resp_exc), 32'(m_exc));
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input logic ij,
                        input int hold, input bit lit, input logic [1:0] lexc,
                        input logic [31:0] ldata, input int llat);
    bit got;
    int seen;
    got = 0; seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_width = w; req_sign = s;
    req_addr = a; req_wdata = d; inj = ij; resp_ready = (hold == 0);
    @(posedge clk);
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1; seen = k;
      end else begin
        req_valid = 1'($urandom); req_we = 1'($urandom); req_width = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_sign = 1'($urandom);
      end
    end
    req_valid = 1'b0;
    if (!got) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else if (lit) begin
      chk("lit_latency", 32'(seen), 32'(llat));
      chk("lit_exc", 32'(resp_exc), 32'(lexc));
      chk("lit_rdata", resp_rdata, ldata);
    end
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    {dmem[16'h43], dmem[16'h42], dmem[16'h41], dmem[16'h40]} = 32'h8001_7FF2;
    {rmem[16'h43], rmem[16'h42], rmem[16'h41], rmem[16'h40]} = 32'h8001_7FF2;
    {dmem[16'h103], dmem[16'h102], dmem[16'h101], dmem[16'h100]} = 32'h1122_3344;
    {rmem[16'h103], rmem[16'h102], rmem[16'h101], rmem[16'h100]} = 32'h1122_3344;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;

    do_req(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 1'b0, 0, 1, 2'b00, 32'hFFFF_FFF2, 3);
    do_req(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 1'b0, 0, 1, 2'b00, 32'h0000_7FF2, 3);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, 0, 1, 2'b00, 32'h8001_7FF2, 3);
    do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h1234_56A5, 1'b0, 0, 1, 2'b00, 32'h0, 2);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, 0, 1, 2'b00, 32'hA522_3344, 3);
    do_req(1'b1, 2'b11, 1'b0, 32'h102, 32'hDEAD_BEEF, 1'b0, 0, 1, 2'b10, 32'h0, 1);
    @(negedge clk); chk("err_after_store_mis", 32'(err_count), 32'd1);
    do_req(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 1'b0, 0, 1, 2'b01, 32'h0, 1);
    @(negedge clk); chk("err_after_half_mis", 32'(err_count), 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 0, 1, 2'b01, 32'h0, 1);
    do_req(1'b0, 2'b11, 1'b0, 32'h0001_0000, 32'h0, 1'b0, 0, 1, 2'b01, 32'h0, 1);
    @(negedge clk); chk("err_after_range", 32'(err_count), 32'd4);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, 5, 1, 2'b00, 32'h8001_7FF2, 3);
    do_req(1'b1, 2'b00, 1'b0, 32'h50, 32'h0000_0077, 1'b1, 0, 1, 2'b10, 32'h0, 2);
    do_req(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 1'b0, 0, 1, 2'b00, 32'h0, 3);
    @(negedge clk); chk("err_after_biterr", 32'(err_count), 32'd5);

    // Reset while the load sits in WAIT; no response may follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 2'b11; req_addr = 32'h40; inj = 1'b0;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      logic        rw, rs, ri;
      logic [1:0]  rwid;
      logic [31:0] ra;
      rw = 1'($urandom); rs = 1'($urandom); rwid = 2'($urandom);
      ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) begin
        if (rwid == 2'b01) ra[0] = 1'b0;
        if (rwid == 2'b11) ra[1:0] = 2'b00;
      end
      ri = ($urandom_range(0, 7) == 0);
      do_req(rw, rwid, rs, ra, $urandom, ri, int'($urandom_range(0, 3)), 0, 2'b00, 32'h0, 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
